// File: rtl/weight_bram_read_sequencer.sv
// rtl/weight_bram_read_sequencer.sv - weight BRAM read sequencer with host write arbitration
//
// Purpose: walks one neuron's weight BRAM (rows 0..DEPTH-1) on start and streams
// the weights to the MAC over a valid/ready handshake. Host weight-update writes
// share the single BRAM port and are served only while no read pass is running.
//
// Ports:
//   CLK, RST          clock (posedge), synchronous active-high reset
//   start             request a read pass (level, sampled in IDLE)
//   busy, done        pass in progress / one-cycle pass-complete pulse
//   bram_*            single-port BRAM control (BRAM is negedge-clocked)
//   bram_do           BRAM read data, captured at the posedge closing the issue cycle
//   w_data, w_idx     weight and row index toward the MAC
//   w_valid, w_ready  weight handshake
//   wr_req/addr/data  host write request, held until wr_ack
//   wr_ack            one-cycle pulse in the cycle the write is issued
//   nz_count          (WSEQ_ZERO_SKIP_EN only) nonzero weights emitted in last pass
//
// Optional feature: define WSEQ_ZERO_SKIP_EN to suppress zero weights on the
// stream and add the nz_count output.

module weight_bram_read_sequencer #(
    parameter int DEPTH = 28,
    parameter int AW    = 5,
    parameter int DW    = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] bram_addr,
    output logic          bram_en,
    output logic          bram_we,
    output logic [DW-1:0] bram_di,
    input  logic [DW-1:0] bram_do,
    output logic [DW-1:0] w_data,
    output logic [AW-1:0] w_idx,
    output logic          w_valid,
    input  logic          w_ready,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
`ifdef WSEQ_ZERO_SKIP_EN
    output logic [AW:0]   nz_count,
`endif
    output logic          wr_ack
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [AW-1:0] LAST_ROW  = AW'(DEPTH - 1);
    localparam logic [AW:0]   DEPTH_EXT = (AW + 1)'(DEPTH);

    state_t          state_q, state_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic            start_pend_q, start_pend_d;
    logic [DW-1:0]   w_data_q, w_data_d;
    logic [AW-1:0]   w_idx_q, w_idx_d;
    logic            w_valid_q, w_valid_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [DW-1:0]   wr_data_q, wr_data_d;
`ifdef WSEQ_ZERO_SKIP_EN
    logic [AW:0]     nz_count_q, nz_count_d;
`endif

    logic issue;
    logic accept;
    logic wr_in_range;

    // A read may issue only when the output register is free or is being
    // emptied at this same edge, so a captured weight never overwrites one
    // the MAC has not taken yet.
    assign issue       = (state_q == S_READ) && (!w_valid_q || w_ready);
    assign accept      = w_valid_q && w_ready;
    assign wr_in_range = ({1'b0, wr_addr_q} < DEPTH_EXT);

    always_comb begin
        state_d      = state_q;
        rd_ptr_d     = rd_ptr_q;
        start_pend_d = start_pend_q;
        w_data_d     = w_data_q;
        w_idx_d      = w_idx_q;
        w_valid_d    = w_valid_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
`ifdef WSEQ_ZERO_SKIP_EN
        nz_count_d   = nz_count_q;
`endif

        if (accept) begin
            w_valid_d = 1'b0;
        end

        // bram_do already reflects rd_ptr_q here: the BRAM updated it on the
        // negedge inside the issue cycle.
        if (issue) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
`ifdef WSEQ_ZERO_SKIP_EN
            if (bram_do != '0) begin
                w_data_d   = bram_do;
                w_idx_d    = rd_ptr_q;
                w_valid_d  = 1'b1;
                nz_count_d = nz_count_q + 1'b1;
            end
`else
            w_data_d  = bram_do;
            w_idx_d   = rd_ptr_q;
            w_valid_d = 1'b1;
`endif
            if (rd_ptr_q == LAST_ROW) begin
                state_d = S_DRAIN;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (wr_req) begin
                    // Writes win; a coincident start is remembered for later.
                    state_d   = S_WRITE;
                    wr_addr_d = wr_addr;
                    wr_data_d = wr_data;
                    if (start) begin
                        start_pend_d = 1'b1;
                    end
                end else if (start || start_pend_q) begin
                    state_d      = S_READ;
                    rd_ptr_d     = '0;
                    start_pend_d = 1'b0;
`ifdef WSEQ_ZERO_SKIP_EN
                    nz_count_d   = '0;
`endif
                end
            end
            S_WRITE: state_d = S_IDLE;
            S_READ:  ;
            S_DRAIN: begin
                // Leaves as soon as the last weight is taken (or was never
                // presented).
                if (!w_valid_d) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= S_IDLE;
            rd_ptr_q     <= '0;
            start_pend_q <= 1'b0;
            w_data_q     <= '0;
            w_idx_q      <= '0;
            w_valid_q    <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
`ifdef WSEQ_ZERO_SKIP_EN
            nz_count_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            rd_ptr_q     <= rd_ptr_d;
            start_pend_q <= start_pend_d;
            w_data_q     <= w_data_d;
            w_idx_q      <= w_idx_d;
            w_valid_q    <= w_valid_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
`ifdef WSEQ_ZERO_SKIP_EN
            nz_count_q   <= nz_count_d;
`endif
        end
    end

    assign busy    = (state_q == S_READ) || (state_q == S_DRAIN) || (state_q == S_DONE);
    assign done    = (state_q == S_DONE);
    assign wr_ack  = (state_q == S_WRITE);

    // Out-of-range host writes are acknowledged but never reach the BRAM.
    assign bram_we = (state_q == S_WRITE) && wr_in_range;
    assign bram_en = issue || bram_we;

    assign bram_addr = (state_q == S_WRITE) ? wr_addr_q :
                       (state_q == S_READ)  ? rd_ptr_q  : '0;
    assign bram_di   = (state_q == S_WRITE) ? wr_data_q : '0;

    assign w_data  = w_data_q;
    assign w_idx   = w_idx_q;
    assign w_valid = w_valid_q;
`ifdef WSEQ_ZERO_SKIP_EN
    assign nz_count = nz_count_q;
`endif

endmodule

// File: tb/tb_weight_bram_read_sequencer.sv
// tb/tb_weight_bram_read_sequencer.sv - directed self-checking bench for weight_bram_read_sequencer

module tb_weight_bram_read_sequencer;

    localparam int DEPTH = 28;
    localparam int AW    = 5;
    localparam int DW    = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy;
    logic          done;
    logic [AW-1:0] bram_addr;
    logic          bram_en;
    logic          bram_we;
    logic [DW-1:0] bram_di;
    logic [DW-1:0] bram_do;
    logic [DW-1:0] w_data;
    logic [AW-1:0] w_idx;
    logic          w_valid;
    logic          w_ready;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ack;
`ifdef WSEQ_ZERO_SKIP_EN
    logic [AW:0]   nz_count;
`endif

    always #5 clk = ~clk;

    weight_bram_read_sequencer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .CLK       (clk),
        .RST       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .bram_addr (bram_addr),
        .bram_en   (bram_en),
        .bram_we   (bram_we),
        .bram_di   (bram_di),
        .bram_do   (bram_do),
        .w_data    (w_data),
        .w_idx     (w_idx),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
`ifdef WSEQ_ZERO_SKIP_EN
        .nz_count  (nz_count),
`endif
        .wr_ack    (wr_ack)
    );

    logic [DW-1:0] mem     [0:31];
    logic [DW-1:0] exp_mem [0:DEPTH-1];

    always @(negedge clk) begin
        if (bram_en) begin
            if (bram_we) mem[bram_addr] <= bram_di;
            else         bram_do        <= mem[bram_addr];
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic int next_idx(input int i);
        int j;
        j = i;
`ifdef WSEQ_ZERO_SKIP_EN
        while (j < DEPTH && exp_mem[j] == '0) j++;
`endif
        return j;
    endfunction

    function automatic int expected_beats();
        int n;
        n = 0;
        for (int i = 0; i < DEPTH; i++) begin
`ifdef WSEQ_ZERO_SKIP_EN
            if (exp_mem[i] != '0) n++;
`else
            n++;
`endif
        end
        return n;
    endfunction

    // Called and returns at posedge+1 of an IDLE cycle (with_start: returns in
    // the IDLE cycle where the pending start is taken).
    task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input bit with_start, input string tag);
        bit seen;
        seen    = 1'b0;
        wr_req  = 1'b1;
        wr_addr = a;
        wr_data = d;
        start   = with_start;
        for (int t = 0; t < 50 && !seen; t++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (wr_ack) begin
                seen = 1'b1;
                check_eq({tag, "_en"}, 32'(bram_en), (int'(a) < DEPTH) ? 32'd1 : 32'd0);
                check_eq({tag, "_we"}, 32'(bram_we), (int'(a) < DEPTH) ? 32'd1 : 32'd0);
                if (int'(a) < DEPTH) begin
                    check_eq({tag, "_addr"}, 32'(bram_addr), 32'(a));
                    check_eq({tag, "_di"},   32'(bram_di),   32'(d));
                end
            end
        end
        wr_req = 1'b0;
        check_eq({tag, "_ack"}, 32'(seen), 32'd1);
        if (int'(a) < DEPTH) exp_mem[a] = d;
        @(posedge clk); #1;
    endtask

    // Starts at posedge+1 of the IDLE cycle that launches the pass.
    task automatic run_pass(input bit do_start, input bit bp, input bit mid_req, input string tag);
        int k, exp_idx, nbeats, busy_cnt, done_k, done_cnt, last_acc_k, ack_k;
        int stall_en, stab_err, exp_beats, idle_bad;
        logic [DW-1:0] pd, exp_d;
        logic [AW-1:0] pi;
        logic [31:0]   nz_at_done;
        bit pstall, fin;

        exp_beats  = expected_beats();
        exp_idx    = next_idx(0);
        nbeats     = 0; busy_cnt = 0; done_k = -1; done_cnt = 0; last_acc_k = -1;
        ack_k      = -1; stall_en = 0; stab_err = 0; pstall = 1'b0; fin = 1'b0;
        nz_at_done = '0; pd = '0; pi = '0;

        start   = do_start;
        w_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 1;
        while (!fin && k < 400) begin
            w_ready = bp ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
            if (mid_req) begin
                if (k == 10) begin
                    wr_req = 1'b1; wr_addr = 5'd5; wr_data = 16'h0BAD;
                end
                start = (k == 12);
            end
            #1;
            if (busy) busy_cnt++;
            if (pstall && (w_data !== pd || w_idx !== pi)) stab_err++;
            if (w_valid && !w_ready && bram_en) stall_en++;
            if (w_valid && w_ready) begin
                exp_d = (exp_idx < DEPTH) ? exp_mem[exp_idx] : '0;
                check_eq({tag, "_idx"},  32'(w_idx),  32'(exp_idx));
                check_eq({tag, "_data"}, 32'(w_data), 32'(exp_d));
                nbeats++;
                last_acc_k = k;
                exp_idx    = next_idx(exp_idx + 1);
            end
            if (done) begin
                done_k = k;
                done_cnt++;
`ifdef WSEQ_ZERO_SKIP_EN
                nz_at_done = 32'(nz_count);
`endif
            end
            if (wr_ack && ack_k < 0) begin
                ack_k  = k;
                wr_req = 1'b0;
            end
            pstall = w_valid && !w_ready;
            pd     = w_data;
            pi     = w_idx;
            fin    = (done_k >= 0) && (!mid_req || ack_k >= 0);
            @(posedge clk); #1;
            k++;
        end
        start = 1'b0;

        check_eq({tag, "_beats"},    32'(nbeats),   32'(exp_beats));
        check_eq({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
        check_eq({tag, "_busy_len"}, 32'(busy_cnt), 32'(done_k));
        check_eq({tag, "_stall_en"}, 32'(stall_en), 32'd0);
        check_eq({tag, "_stable"},   32'(stab_err), 32'd0);
        if (exp_mem[DEPTH-1] != '0)
            check_eq({tag, "_done_lat"}, 32'(done_k), 32'(last_acc_k + 1));
        if (!bp)
            check_eq({tag, "_done_k"}, 32'(done_k), 32'(DEPTH + 2));
        if (mid_req) begin
            check_eq({tag, "_ack_seen"},  32'(ack_k >= 0),     32'd1);
            check_eq({tag, "_ack_after"}, 32'(ack_k > done_k), 32'd1);
            exp_mem[5] = 16'h0BAD;
        end
`ifdef WSEQ_ZERO_SKIP_EN
        check_eq({tag, "_nz_count"}, nz_at_done, 32'(exp_beats));
`endif

        idle_bad = 0;
        for (int t = 0; t < 20; t++) begin
            if (busy || w_valid || done) idle_bad++;
            @(posedge clk); #1;
        end
        check_eq({tag, "_no_extra_pass"}, 32'(idle_bad), 32'd0);
    endtask

    initial begin
        int found, bad;
        rst = 1'b1; start = 1'b0; w_ready = 1'b0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        bram_do = '0;
        for (int i = 0; i < 32; i++) mem[i] = 16'hDEAD;
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = 16'hDEAD;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy",    32'(busy),      32'd0);
        check_eq("rst_done",    32'(done),      32'd0);
        check_eq("rst_en",      32'(bram_en),   32'd0);
        check_eq("rst_we",      32'(bram_we),   32'd0);
        check_eq("rst_addr",    32'(bram_addr), 32'd0);
        check_eq("rst_di",      32'(bram_di),   32'd0);
        check_eq("rst_w_data",  32'(w_data),    32'd0);
        check_eq("rst_w_idx",   32'(w_idx),     32'd0);
        check_eq("rst_w_valid", 32'(w_valid),   32'd0);
        check_eq("rst_wr_ack",  32'(wr_ack),    32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < DEPTH; i++)
            host_write(AW'(i), DW'(i - 14), 1'b0, "preload");

        host_write(5'd30, 16'h1234, 1'b0, "wr_oor");
        check_eq("wr_oor_mem", 32'(mem[30]), 32'h0000DEAD);

        run_pass(1'b1, 1'b0, 1'b0, "full");
        run_pass(1'b1, 1'b1, 1'b0, "bp");

        host_write(5'd3, 16'h7FFF, 1'b1, "wtr");
        check_eq("wtr_idle_busy", 32'(busy), 32'd0);
        run_pass(1'b0, 1'b0, 1'b0, "wtr_pass");

        run_pass(1'b1, 1'b0, 1'b1, "wbusy");

        // Reset in the middle of a pass, while row 10 is being issued.
        start = 1'b1; w_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        found = 0;
        for (int t = 0; t < 50 && found == 0; t++) begin
            if (bram_en && bram_addr == 5'd10) found = 1;
            else begin @(posedge clk); #1; end
        end
        check_eq("midrst_reach10", 32'(found), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("midrst_busy",    32'(busy),      32'd0);
        check_eq("midrst_done",    32'(done),      32'd0);
        check_eq("midrst_en",      32'(bram_en),   32'd0);
        check_eq("midrst_addr",    32'(bram_addr), 32'd0);
        check_eq("midrst_w_valid", 32'(w_valid),   32'd0);
        check_eq("midrst_w_data",  32'(w_data),    32'd0);
        check_eq("midrst_w_idx",   32'(w_idx),     32'd0);
        rst = 1'b0;
        bad = 0;
        for (int t = 0; t < 20; t++) begin
            @(posedge clk); #1;
            if (busy || done || w_valid || bram_en) bad++;
        end
        check_eq("midrst_quiet", 32'(bad), 32'd0);

`ifdef WSEQ_ZERO_SKIP_EN
        host_write(5'd5,  16'h0000, 1'b0, "zs_w5");
        host_write(5'd6,  16'h0000, 1'b0, "zs_w6");
        host_write(5'd14, 16'h0001, 1'b0, "zs_w14");
        host_write(5'd27, 16'h0000, 1'b0, "zs_w27");
        check_eq("zs_expected_25", 32'(expected_beats()), 32'd25);
        run_pass(1'b1, 1'b0, 1'b0, "zskip");
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
